// File: rtl/mccpu_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DCD/EXE/MEM/WB, outputs decoded from state, Op, Funct, Zero.
// j/jal 2 cycles, beq 3, sw and ALU ops 4, lw 5; no backpressure, every state advances each clk.
module mccpu_ctrl #(
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWr,
  output logic               IRWr,
  output logic               RFWr,
  output logic               DMWr,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [3:0]         ALUOp,
  output logic [1:0]         NPCOp,
  output logic [1:0]         GPRSel,
  output logic [1:0]         WDSel,
  output logic [STATE_W-1:0] State
);

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH = STATE_W'(0),
    S_DCD   = STATE_W'(1),
    S_EXE   = STATE_W'(2),
    S_MEM   = STATE_W'(3),
    S_WB    = STATE_W'(4)
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_rtype, w_lw, w_sw, w_beq, w_j, w_jal;
  logic       w_op_ok, w_fn_ok, w_shift, w_srcb_sext, w_srcb_zext;
  logic [3:0] w_alu;

  assign w_rtype = (Op == OP_RTYPE);
  assign w_lw    = (Op == OP_LW);
  assign w_sw    = (Op == OP_SW);
  assign w_beq   = (Op == OP_BEQ);
  assign w_j     = (Op == OP_J);
  assign w_jal   = (Op == OP_JAL);

  // Instruction decode, independent of state; only consumed in EXE/DCD.
  always_comb begin
    w_alu       = ALU_NOP;
    w_op_ok     = 1'b1;
    w_fn_ok     = 1'b0;
    w_shift     = 1'b0;
    w_srcb_sext = 1'b0;
    w_srcb_zext = 1'b0;
    if (w_rtype) begin
      w_fn_ok = 1'b1;
      case (Funct)
        F_ADD:   w_alu = ALU_ADD;
        F_SUB:   w_alu = ALU_SUB;
        F_AND:   w_alu = ALU_AND;
        F_OR:    w_alu = ALU_OR;
        F_NOR:   w_alu = ALU_NOR;
        F_SLT:   w_alu = ALU_SLT;
        F_SLTU:  w_alu = ALU_SLTU;
        F_SLL:   begin w_alu = ALU_SLL; w_shift = 1'b1; end
        F_SRL:   begin w_alu = ALU_SRL; w_shift = 1'b1; end
        default: w_fn_ok = 1'b0;
      endcase
    end else begin
      case (Op)
        OP_ADDI, OP_LW, OP_SW: begin w_alu = ALU_ADD; w_srcb_sext = 1'b1; end
        OP_SLTI: begin w_alu = ALU_SLT; w_srcb_sext = 1'b1; end
        OP_ANDI: begin w_alu = ALU_AND; w_srcb_zext = 1'b1; end
        OP_ORI:  begin w_alu = ALU_OR;  w_srcb_zext = 1'b1; end
        OP_LUI:  begin w_alu = ALU_LUI; w_srcb_zext = 1'b1; end
        OP_BEQ:  w_alu = ALU_SUB;
        OP_J, OP_JAL: w_alu = ALU_NOP;
        default: w_op_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next  = S_FETCH;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'd0;
    ALUOp   = ALU_NOP;
    NPCOp   = 2'd0;
    GPRSel  = 2'd0;
    WDSel   = 2'd0;
    case (r_state)
      S_FETCH: begin
        IRWr   = 1'b1;
        PCWr   = 1'b1;
        w_next = S_DCD;
      end
      S_DCD: begin
        if (w_j || w_jal) begin
          PCWr  = 1'b1;
          NPCOp = 2'd2;
          if (w_jal) begin
            RFWr   = 1'b1;
            GPRSel = 2'd2;
            WDSel  = 2'd2;
          end
        end else if (w_op_ok) begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        ALUOp   = w_alu;
        ALUSrcA = w_shift;
        ALUSrcB = w_srcb_sext ? 2'd1 : (w_srcb_zext ? 2'd2 : 2'd0);
        if (w_beq) begin
          NPCOp = 2'd1;
          PCWr  = Zero;
        end else if (w_lw || w_sw) begin
          w_next = S_MEM;
        end else if (w_rtype ? w_fn_ok : w_op_ok) begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (w_sw)      DMWr   = 1'b1;
        else if (w_lw) w_next = S_WB;
      end
      S_WB: begin
        RFWr   = 1'b1;
        GPRSel = w_rtype ? 2'd0 : 2'd1;
        WDSel  = w_lw ? 2'd1 : 2'd0;
      end
      default: w_next = S_FETCH;
    endcase
    // FETCH is the reset state but must not fire its enables while held in reset.
    if (!rstn) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RFWr    = 1'b0;
      DMWr    = 1'b0;
      ALUSrcA = 1'b0;
      ALUSrcB = 2'd0;
      ALUOp   = ALU_NOP;
      NPCOp   = 2'd0;
      GPRSel  = 2'd0;
      WDSel   = 2'd0;
    end
  end

  assign State = r_state;

endmodule

// File: tb/tb_mccpu_ctrl.sv
// Bench for mccpu_ctrl: per-instruction table expanded into per-cycle expected outputs,
// queued as each instruction is driven and compared half a cycle later.
module tb_mccpu_ctrl;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  typedef enum logic [2:0] {K_ALU, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_BADOP, K_BADFN} kind_t;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr;
    logic       irwr;
    logic       rfwr;
    logic       dmwr;
    logic       srca;
    logic [1:0] srcb;
    logic [3:0] alu;
    logic [1:0] npc;
    logic [1:0] gpr;
    logic [1:0] wd;
  } out_t;

  typedef struct {
    string      name;
    kind_t      k;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] gpr;
    logic [1:0] wd;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero;
  logic       PCWr, IRWr, RFWr, DMWr, ALUSrcA;
  logic [1:0] ALUSrcB, NPCOp, GPRSel, WDSel;
  logic [3:0] ALUOp;
  logic [2:0] State;
  out_t       act;

  out_t sb[$];
  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  mccpu_ctrl #(.STATE_W(3)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .GPRSel(GPRSel), .WDSel(WDSel), .State(State)
  );

  always #5 clk = ~clk;

  assign act = {State, PCWr, IRWr, RFWr, DMWr, ALUSrcA, ALUSrcB, ALUOp, NPCOp, GPRSel, WDSel};

  function automatic vec_t mk(string n, kind_t k, logic [5:0] op, logic [5:0] fn, logic z,
                              logic [3:0] alu, logic sa, logic [1:0] sbv, logic [1:0] gpr,
                              logic [1:0] wd);
    vec_t v;
    v.name = n; v.k = k; v.op = op; v.fn = fn; v.z = z;
    v.alu = alu; v.srca = sa; v.srcb = sbv; v.gpr = gpr; v.wd = wd;
    return v;
  endfunction

  function automatic int len_of(kind_t k);
    case (k)
      K_J, K_JAL, K_BADOP: return 2;
      K_BEQ, K_BADFN:      return 3;
      K_LW:                return 5;
      default:             return 4;
    endcase
  endfunction

  function automatic out_t exp_of(vec_t v, int c);
    out_t e;
    e = '0;
    case (c)
      0: begin e.st = 3'd0; e.irwr = 1'b1; e.pcwr = 1'b1; end
      1: begin
        e.st = 3'd1;
        if (v.k == K_J || v.k == K_JAL) begin e.pcwr = 1'b1; e.npc = 2'd2; end
        if (v.k == K_JAL) begin e.rfwr = 1'b1; e.gpr = 2'd2; e.wd = 2'd2; end
      end
      2: begin
        e.st = 3'd2; e.alu = v.alu; e.srca = v.srca; e.srcb = v.srcb;
        if (v.k == K_BEQ) begin e.npc = 2'd1; e.pcwr = v.z; end
      end
      3: begin
        if (v.k == K_LW || v.k == K_SW) begin
          e.st = 3'd3; e.dmwr = (v.k == K_SW);
        end else begin
          e.st = 3'd4; e.rfwr = 1'b1; e.gpr = v.gpr; e.wd = v.wd;
        end
      end
      default: begin e.st = 3'd4; e.rfwr = 1'b1; e.gpr = v.gpr; e.wd = v.wd; end
    endcase
    return e;
  endfunction

  task automatic check(string tag);
    out_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: got=%h but no expected entry queued", tag, act);
    end else begin
      e = sb.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got=%h exp=%h", tag, act, e);
      end
    end
  endtask

  // Called at a falling edge; leaves the bench at the falling edge after ncyc cycles.
  task automatic run(vec_t v, int ncyc, string name);
    Op    = v.op;
    Funct = v.fn;
    Zero  = (v.k == K_BEQ) ? v.z : 1'($urandom_range(0, 1));
    for (int c = 0; c < ncyc; c++) sb.push_back(exp_of(v, c));
    for (int c = 0; c < ncyc; c++) begin
      #1;
      check($sformatf("%s_c%0d", name, c));
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    tbl.push_back(mk("add",   K_ALU,   6'h00, 6'h20, 1'b0, ALU_ADD,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("lw",    K_LW,    6'h23, 6'h11, 1'b0, ALU_ADD,  1'b0, 2'd1, 2'd1, 2'd1));
    tbl.push_back(mk("beq_z1",K_BEQ,   6'h04, 6'h00, 1'b1, ALU_SUB,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("beq_z0",K_BEQ,   6'h04, 6'h00, 1'b0, ALU_SUB,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("jal",   K_JAL,   6'h03, 6'h20, 1'b0, ALU_NOP,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("j",     K_J,     6'h02, 6'h00, 1'b0, ALU_NOP,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("sll",   K_ALU,   6'h00, 6'h00, 1'b0, ALU_SLL,  1'b1, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("srl",   K_ALU,   6'h00, 6'h02, 1'b0, ALU_SRL,  1'b1, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("lui",   K_ALU,   6'h0f, 6'h2a, 1'b0, ALU_LUI,  1'b0, 2'd2, 2'd1, 2'd0));
    tbl.push_back(mk("sub",   K_ALU,   6'h00, 6'h22, 1'b0, ALU_SUB,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("and",   K_ALU,   6'h00, 6'h24, 1'b0, ALU_AND,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("or",    K_ALU,   6'h00, 6'h25, 1'b0, ALU_OR,   1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("nor",   K_ALU,   6'h00, 6'h27, 1'b0, ALU_NOR,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("slt",   K_ALU,   6'h00, 6'h2a, 1'b0, ALU_SLT,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("sltu",  K_ALU,   6'h00, 6'h2b, 1'b0, ALU_SLTU, 1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("addi",  K_ALU,   6'h08, 6'h24, 1'b0, ALU_ADD,  1'b0, 2'd1, 2'd1, 2'd0));
    tbl.push_back(mk("andi",  K_ALU,   6'h0c, 6'h00, 1'b0, ALU_AND,  1'b0, 2'd2, 2'd1, 2'd0));
    tbl.push_back(mk("ori",   K_ALU,   6'h0d, 6'h02, 1'b0, ALU_OR,   1'b0, 2'd2, 2'd1, 2'd0));
    tbl.push_back(mk("slti",  K_ALU,   6'h0a, 6'h3f, 1'b0, ALU_SLT,  1'b0, 2'd1, 2'd1, 2'd0));
    tbl.push_back(mk("sw",    K_SW,    6'h2b, 6'h20, 1'b0, ALU_ADD,  1'b0, 2'd1, 2'd0, 2'd0));
    tbl.push_back(mk("badop", K_BADOP, 6'h3f, 6'h20, 1'b0, ALU_NOP,  1'b0, 2'd0, 2'd0, 2'd0));
    tbl.push_back(mk("badfn", K_BADFN, 6'h00, 6'h3f, 1'b0, ALU_NOP,  1'b0, 2'd0, 2'd0, 2'd0));

    // Held in reset with a jal presented: everything must read zero.
    rstn  = 1'b0;
    Op    = 6'h03;
    Funct = 6'h00;
    Zero  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    sb.push_back('0);
    check("reset_hold");
    rstn = 1'b1;

    foreach (tbl[i]) run(tbl[i], len_of(tbl[i].k), tbl[i].name);

    // sw interrupted by reset while in EXE; DMWr must never fire.
    run(tbl[19], 2, "sw_rst_pre");
    sb.push_back(exp_of(tbl[19], 2));
    #1;
    check("sw_rst_exe");
    #2;
    rstn = 1'b0;
    #1;
    sb.push_back('0);
    check("sw_rst_async");
    @(posedge clk);
    @(negedge clk);
    #1;
    sb.push_back('0);
    check("sw_rst_held");
    rstn = 1'b1;
    run(tbl[0], 4, "resume_add");
    sb.push_back(exp_of(tbl[0], 0));
    #1;
    check("final_fetch");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got=%0d leftover entries exp=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mccpu_ctrl.md
MCCPU_CTRL -- requirements
Module: mccpu_ctrl

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- Op  in  6  instruction[31:26]
- Funct  in  6  instruction[5:0]
- Zero  in  1  ALU Zero flag (combinational, same cycle)
- PCWr  out  1  PC write enable
- IRWr  out  1  IR write enable
- RFWr  out  1  register-file write enable
- DMWr  out  1  data-memory write enable
- ALUSrcA  out  1  0 = rs, 1 = zero-extended shamt
- ALUSrcB  out  2  0 = rt, 1 = sign-ext imm16, 2 = zero-ext imm16
- ALUOp  out  4  ALU operation, using the shared ALU_* encodings
- NPCOp  out  2  0 = PC+4, 1 = branch, 2 = jump
- GPRSel  out  2  0 = rd, 1 = rt, 2 = r31
- WDSel  out  2  0 = ALU result, 1 = memory data, 2 = PC+4
- State  out  3  current state, for debug

REQ-002 SHALL have one parameter: STATE_W, default 3, the state register width.

Function
REQ-003 SHALL be a Moore/Mealy FSM with five states: FETCH=0, DCD=1, EXE=2, MEM=3, WB=4. Outputs are combinational from the state, Op, Funct and Zero. The only register is the state register.
REQ-004 The supported set SHALL be:
- R-type (Op=000000) with Funct add 100000, sub 100010, and 100100, or 100101, nor 100111, slt 101010, sltu 101011, sll 000000, srl 000010
- addi 001000, andi 001100, ori 001101, slti 001010, lui 001111
- lw 100011, sw 101011, beq 000100, j 000010, jal 000011
REQ-005 FETCH SHALL assert IRWr=1, PCWr=1, NPCOp=0 and go to DCD.
REQ-006 DCD, for j, SHALL assert PCWr=1, NPCOp=2 and go to FETCH.
REQ-007 DCD, for jal, SHALL additionally assert RFWr=1, GPRSel=2, WDSel=2.
REQ-008 DCD, for any other supported Op, SHALL go to EXE.
REQ-009 DCD, for an unsupported Op, SHALL go to FETCH with all enables 0.
REQ-010 EXE SHALL drive ALUSrcA=1 only for sll/srl.
REQ-011 EXE SHALL drive ALUSrcB: 1 for addi, slti, lw, sw; 2 for andi, ori, lui; otherwise 0.
REQ-012 EXE SHALL drive ALUOp from the instruction: add, sub, and, or, nor, slt, sltu, sll, srl; addi/lw/sw = ADD; andi = AND; ori = OR; slti = SLT; lui = LUI; beq = SUB.
REQ-013 An unsupported R-type Funct in EXE SHALL give ALUOp = NOP and go to FETCH.
REQ-014 EXE, for beq, SHALL set NPCOp=1, set PCWr equal to Zero in that cycle, and go to FETCH.
REQ-015 EXE SHALL go to MEM for lw/sw, and to WB for R-type and I-type ALU instructions.
REQ-016 MEM, for sw, SHALL assert DMWr=1 and go to FETCH; for lw it SHALL go to WB.
REQ-017 WB SHALL assert RFWr=1, with GPRSel=0 for R-type and 1 otherwise, and WDSel=1 for lw and 0 otherwise; it SHALL then go to FETCH.
REQ-018 In every state, any enable not listed for that state SHALL be 0, and ALUOp SHALL be NOP.
REQ-019 Instruction latency in cycles SHALL be: j/jal 2, beq 3, sw 4, R/I ALU 4, lw 5.
REQ-020 Unreachable state encodings 5–7 SHALL go to FETCH on the next edge with all enables 0.

Reset
REQ-021 rstn low SHALL force State=FETCH asynchronously, independent of clk.
REQ-022 While rstn is low, PCWr, IRWr, RFWr and DMWr SHALL be 0, and all select outputs and ALUOp SHALL be 0.
REQ-023 The first rising clk edge after rstn deasserts SHALL complete a FETCH.
REQ-024 Reset asserted mid-instruction SHALL abandon that instruction with no further write enables.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset release then add (Op=0, Funct=100000) -> State 0,1,2,4,0; ALUOp=ADD in EXE; RFWr=1 with GPRSel=0 in WB only.
- lw -> 5 cycles; ALUSrcB=1 in EXE; WB has WDSel=1, GPRSel=1; DMWr never 1.
- beq with Zero=1, then with Zero=0 -> PCWr=1/NPCOp=1 in EXE for the first; PCWr=0 in EXE for the second; both return to FETCH after 3 cycles.
- jal -> DCD asserts PCWr=1, NPCOp=2, RFWr=1, GPRSel=2, WDSel=2; next State=FETCH.
- sll -> ALUSrcA=1, ALUOp=SLL in EXE; lui -> ALUSrcB=2, ALUOp=LUI.
- rstn pulled low mid-EXE of sw -> State=0 immediately; DMWr stays 0; execution resumes with FETCH after release.
